eth_tx_framer: RTL and testbench



---
 rtl/eth_pkg.sv | 30 +++
 rtl/eth_tx_framer_crc32_d8.sv | 32 +++
 rtl/eth_tx_framer.sv | 187 ++++++++++++++++++
 tb/tb_eth_tx_framer.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_pkg
// Description : Ethernet framing constants, CRC-32 constants and framer states
// Revision    : 1.0 - initial release
// ============================================================================
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
    localparam logic [7:0]  ETH_SFD         = 8'hD5;
    localparam logic [15:0] ETH_MIN_PAYLOAD = 16'd46;
    localparam logic [15:0] ETH_HDR_LEN     = 16'd14;
    localparam logic [15:0] ETH_FCS_LEN     = 16'd4;
    localparam logic [15:0] ETH_PRE_LEN     = 16'd8;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_HDR  = 3'd2,
        ST_PAY  = 3'd3,
        ST_PAD  = 3'd4,
        ST_FCS  = 3'd5,
        ST_IFG  = 3'd6
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/eth_tx_framer_crc32_d8.sv
`default_nettype none
// ============================================================================
// Module      : crc32_d8
// Description : Combinational reflected CRC-32 update for one data byte
// Revision    : 1.0 - initial release
// ============================================================================
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] i_crc_in,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc_out
);

    logic [31:0] w_crc;

    // LSB-first bit-serial update unrolled over the eight data bits
    always_comb begin
        w_crc = i_crc_in ^ {24'd0, i_data};
        for (int b = 0; b < 8; b++) begin
            if (w_crc[0]) begin
                w_crc = (w_crc >> 1) ^ CRC32_POLY_REFL;
            end else begin
                w_crc = w_crc >> 1;
            end
        end
    end

    assign o_crc_out = w_crc;

endmodule
`default_nettype wire

// File: rtl/eth_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : eth_tx_framer
// Description : Buffers one payload and emits a full Ethernet II frame on GMII
// Revision    : 1.0 - initial release
// ============================================================================
module eth_tx_framer
    import eth_pkg::*;
#(
    parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC     = 48'h0200_0000_0001,
    parameter logic [15:0] ETHERTYPE   = 16'h88B5,
    parameter int          MAX_PAYLOAD = 64,
    parameter int          IFG_CYCLES  = 12
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_wdata,
    input  logic       i_wvalid,
    input  logic       i_wlast,
    output logic       o_wready,
    output logic [7:0] o_txd,
    output logic       o_txen,
    output logic       o_busy,
    output logic       o_sent
);

    localparam int IDX_W = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

    localparam logic [15:0]        c_MAX_LEN  = 16'(MAX_PAYLOAD);
    localparam logic [15:0]        c_IFG_LAST = 16'(IFG_CYCLES - 1);
    localparam logic [13:0][7:0]   c_HDR      = {DST_MAC, SRC_MAC, ETHERTYPE};

    tx_state_t   state_q;
    tx_state_t   state_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic [15:0] len_q;
    logic [31:0] crc_q;
    logic [7:0]  mem_q [MAX_PAYLOAD];

    logic        wready_q;
    logic        txen_q;
    logic        busy_q;
    logic        sent_q;
    logic [7:0]  txd_q;
    logic [7:0]  txd_d;

    logic            w_accept;
    logic            w_close;
    logic [31:0]     w_crc_next;
    logic [31:0]     w_crc_final;
    logic [3:0][7:0] w_fcs;

    assign w_accept = wready_q & i_wvalid;
    assign w_close  = w_accept & (i_wlast | ((len_q + 16'd1) == c_MAX_LEN));

    // CRC absorbs the byte currently on o_txd
    crc32_d8 u_crc (
        .i_crc_in  (crc_q),
        .i_data    (txd_q),
        .o_crc_out (w_crc_next)
    );

    // The first FCS byte is registered while the last data byte is still on
    // the wire, so it must be taken from the not-yet-registered CRC.
    assign w_crc_final = (state_q == ST_FCS) ? crc_q : w_crc_next;
    assign w_fcs       = ~w_crc_final;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (w_close) begin
                    state_d = ST_PRE;
                end
            end
            ST_PRE: begin
                if (cnt_q == ETH_PRE_LEN - 16'd1) begin
                    state_d = ST_HDR;
                    cnt_d   = '0;
                end
            end
            ST_HDR: begin
                if (cnt_q == ETH_HDR_LEN - 16'd1) begin
                    state_d = ST_PAY;
                    cnt_d   = '0;
                end
            end
            ST_PAY: begin
                if (cnt_q == len_q - 16'd1) begin
                    state_d = (len_q >= ETH_MIN_PAYLOAD) ? ST_FCS : ST_PAD;
                    cnt_d   = '0;
                end
            end
            ST_PAD: begin
                if (cnt_q == ETH_MIN_PAYLOAD - len_q - 16'd1) begin
                    state_d = ST_FCS;
                    cnt_d   = '0;
                end
            end
            ST_FCS: begin
                if (cnt_q == ETH_FCS_LEN - 16'd1) begin
                    state_d = ST_IFG;
                    cnt_d   = '0;
                end
            end
            ST_IFG: begin
                if (cnt_q == c_IFG_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Byte for the upcoming cycle, selected from the next state so that the
    // transmit outputs can be registered without an extra cycle of latency.
    always_comb begin
        txd_d = '0;
        case (state_d)
            ST_PRE:  txd_d = (cnt_d == ETH_PRE_LEN - 16'd1) ? ETH_SFD : ETH_PREAMBLE;
            ST_HDR:  txd_d = c_HDR[4'd13 - cnt_d[3:0]];
            ST_PAY:  txd_d = mem_q[cnt_d[IDX_W-1:0]];
            ST_FCS:  txd_d = w_fcs[cnt_d[1:0]];
            default: txd_d = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            len_q    <= '0;
            crc_q    <= CRC32_INIT;
            wready_q <= 1'b0;
            txen_q   <= 1'b0;
            busy_q   <= 1'b0;
            sent_q   <= 1'b0;
            txd_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            txd_q    <= txd_d;
            txen_q   <= state_d inside {ST_PRE, ST_HDR, ST_PAY, ST_PAD, ST_FCS};
            busy_q   <= (state_d != ST_IDLE);
            wready_q <= (state_d == ST_IDLE);
            sent_q   <= (state_d == ST_FCS) && (cnt_d == ETH_FCS_LEN - 16'd1);

            if (w_accept) begin
                len_q <= len_q + 16'd1;
            end else if ((state_q == ST_IFG) && (state_d == ST_IDLE)) begin
                len_q <= '0;
            end

            case (state_q)
                ST_HDR, ST_PAY, ST_PAD: crc_q <= w_crc_next;
                ST_IFG:                 crc_q <= CRC32_INIT;
                default:                crc_q <= crc_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < MAX_PAYLOAD; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_accept) begin
            mem_q[len_q[IDX_W-1:0]] <= i_wdata;
        end
    end

    assign o_wready = wready_q;
    assign o_txd    = txd_q;
    assign o_txen   = txen_q;
    assign o_busy   = busy_q;
    assign o_sent   = sent_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_tx_framer
// Description : Self-checking bench for eth_tx_framer against a frame model
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_tx_framer;

    typedef logic [7:0] bq_t[$];

    localparam int          IFG   = 12;
    localparam logic [47:0] M_DST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] M_SRC = 48'h0200_0000_0001;
    localparam logic [15:0] M_ET  = 16'h88B5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wdata = '0;
    logic       wvalid = 1'b0;
    logic       wlast = 1'b0;
    logic       o_wready;
    logic [7:0] o_txd;
    logic       o_txen;
    logic       o_busy;
    logic       o_sent;

    logic [31:0] tb_crc_in = '0;
    logic [7:0]  tb_crc_data = '0;
    logic [31:0] tb_crc_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    eth_tx_framer dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_wdata  (wdata),
        .i_wvalid (wvalid),
        .i_wlast  (wlast),
        .o_wready (o_wready),
        .o_txd    (o_txd),
        .o_txen   (o_txen),
        .o_busy   (o_busy),
        .o_sent   (o_sent)
    );

    crc32_d8 u_crc_chk (
        .i_crc_in  (tb_crc_in),
        .i_data    (tb_crc_data),
        .o_crc_out (tb_crc_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference frame: preamble, header, payload, zero pad, FCS (LSB first)
    function automatic bq_t build_frame(bq_t pay);
        bq_t         f;
        bq_t         body;
        logic [31:0] c;
        logic [47:0] d;
        logic [47:0] s;
        logic [15:0] e;
        d = M_DST;
        s = M_SRC;
        e = M_ET;
        for (int i = 0; i < 7; i++) f.push_back(8'h55);
        f.push_back(8'hD5);
        for (int i = 0; i < 6; i++) body.push_back(d[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) body.push_back(s[47-8*i -: 8]);
        body.push_back(e[15:8]);
        body.push_back(e[7:0]);
        foreach (pay[i]) body.push_back(pay[i]);
        while (body.size() < 60) body.push_back(8'h00);
        c = 32'hFFFF_FFFF;
        foreach (body[i]) begin
            c = c ^ {24'd0, body[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        c = ~c;
        foreach (body[i]) f.push_back(body[i]);
        f.push_back(c[7:0]);
        f.push_back(c[15:8]);
        f.push_back(c[23:16]);
        f.push_back(c[31:24]);
        return f;
    endfunction

    function automatic bq_t rand_payload(int n);
        bq_t p;
        for (int i = 0; i < n; i++) p.push_back(8'($urandom));
        return p;
    endfunction

    task automatic load(input bq_t pay, input string name);
        int t;
        for (int i = 0; i < pay.size(); i++) begin
            wvalid = 1'b1;
            wdata  = pay[i];
            wlast  = (i == pay.size() - 1);
            t = 0;
            while (o_wready !== 1'b1 && t < 500) begin
                step();
                t++;
            end
            if (o_wready !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL %s load_timeout: byte %0d wready=%b required 1", name, i, o_wready);
                wvalid = 1'b0;
                wlast  = 1'b0;
                return;
            end
            step();
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic check_frame(input bq_t pay, input string name);
        bq_t exp;
        bq_t got;
        int  t;
        int  sent_idx;
        int  gap;
        int  bad;
        int  first_bad;
        bit  ifg_ok;
        exp = build_frame(pay);
        t = 0;
        while (o_txen !== 1'b1 && t < 3000) begin
            step();
            t++;
        end
        if (o_txen !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s start: txen=%b required 1", name, o_txen);
            return;
        end
        sent_idx = -1;
        while (o_txen === 1'b1 && got.size() < 2000) begin
            got.push_back(o_txd);
            if (o_sent === 1'b1) sent_idx = got.size();
            step();
        end
        checks++;
        if (got.size() !== exp.size()) begin
            errors++;
            $display("FAIL %s length: got %0d bytes required %0d", name, got.size(), exp.size());
        end
        bad = 0;
        first_bad = -1;
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            if (got[i] !== exp[i]) begin
                if (bad == 0) first_bad = i;
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s bytes: %0d wrong, first at %0d got %02h required %02h",
                     name, bad, first_bad, got[first_bad], exp[first_bad]);
        end
        checks++;
        if (sent_idx !== exp.size()) begin
            errors++;
            $display("FAIL %s sent_pos: got %0d required %0d", name, sent_idx, exp.size());
        end
        gap = 0;
        ifg_ok = 1'b1;
        while (o_wready !== 1'b1 && gap < 200) begin
            if (o_busy !== 1'b1 || o_txen !== 1'b0 || o_txd !== 8'h00) ifg_ok = 1'b0;
            gap++;
            step();
        end
        checks++;
        if (gap !== IFG) begin
            errors++;
            $display("FAIL %s ifg_len: got %0d required %0d", name, gap, IFG);
        end
        checks++;
        if (ifg_ok !== 1'b1) begin
            errors++;
            $display("FAIL %s ifg_state: got bad busy/txen/txd, required busy=1 txen=0 txd=00", name);
        end
    endtask

    task automatic test_crc_vector();
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < 9; i++) begin
            tb_crc_in   = c;
            tb_crc_data = 8'h31 + 8'(i);
            #1;
            c = tb_crc_out;
        end
        checks++;
        if (~c !== 32'hCBF4_3926) begin
            errors++;
            $display("FAIL crc_check: got %08h required cbf43926", ~c);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if ({o_wready, o_txen, o_busy, o_sent, o_txd} !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs: got wready=%b txen=%b busy=%b sent=%b txd=%02h required all 0",
                     o_wready, o_txen, o_busy, o_sent, o_txd);
        end
        rst = 1'b0;
        step();
        checks++;
        if (o_wready !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got wready=%b busy=%b required 1 0", o_wready, o_busy);
        end
    endtask

    task automatic test_single_byte();
        bq_t p;
        p.push_back(8'hA5);
        load(p, "single");
        check_frame(p, "single");
    endtask

    task automatic test_min_payload();
        bq_t p;
        for (int i = 0; i < 46; i++) p.push_back(8'(i));
        load(p, "len46");
        check_frame(p, "len46");
    endtask

    task automatic test_random_frames();
        bq_t p;
        int  n;
        for (int k = 0; k < 4; k++) begin
            n = (k == 0) ? 64 : $urandom_range(1, 63);
            p = rand_payload(n);
            load(p, $sformatf("rand%0d", k));
            check_frame(p, $sformatf("rand%0d", k));
        end
    endtask

    task automatic test_truncation();
        bq_t all;
        bq_t f1;
        bq_t f2;
        all = rand_payload(70);
        for (int i = 0; i < 70; i++) begin
            if (i < 64) f1.push_back(all[i]);
            else        f2.push_back(all[i]);
        end
        fork
            load(all, "trunc");
            begin
                check_frame(f1, "trunc_f1");
                check_frame(f2, "trunc_f2");
            end
        join
    endtask

    task automatic test_reset_mid_frame();
        bq_t p;
        p.push_back(8'h11);
        p.push_back(8'h22);
        load(p, "midrst");
        repeat (13) step();
        checks++;
        if (o_txen !== 1'b1 || o_txd !== 8'hFF) begin
            errors++;
            $display("FAIL midrst_hdr5: got txen=%b txd=%02h required 1 ff", o_txen, o_txd);
        end
        rst = 1'b1;
        step();
        checks++;
        if (o_txen !== 1'b0 || o_wready !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_abort: got txen=%b wready=%b busy=%b required 0 0 0",
                     o_txen, o_wready, o_busy);
        end
        rst = 1'b0;
        step();
        checks++;
        if (o_wready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ready: got wready=%b required 1", o_wready);
        end
        p = rand_payload($urandom_range(1, 50));
        load(p, "after_rst");
        check_frame(p, "after_rst");
    endtask

    task automatic test_hold_valid_busy();
        bq_t p;
        bq_t q;
        bit  viol;
        int  since;
        p = rand_payload(10);
        load(p, "hold");
        viol  = 1'b0;
        since = -1;
        fork
            check_frame(p, "hold");
            begin
                wvalid = 1'b1;
                for (int n = 0; n < 400; n++) begin
                    wlast = 1'($urandom_range(0, 1));
                    wdata = 8'($urandom);
                    if (o_busy === 1'b1 && o_wready !== 1'b0) viol = 1'b1;
                    if (o_wready === 1'b1) break;
                    if (o_sent === 1'b1) since = 0;
                    else if (since >= 0) since++;
                    step();
                end
            end
        join
        checks++;
        if (viol !== 1'b0) begin
            errors++;
            $display("FAIL hold_ready_busy: got wready=1 while busy, required 0");
        end
        checks++;
        if (since !== IFG) begin
            errors++;
            $display("FAIL hold_ready_gap: got %0d cycles after sent, required %0d", since, IFG);
        end
        wdata = 8'h3C;
        wlast = 1'b1;
        step();
        wvalid = 1'b0;
        wlast  = 1'b0;
        q.push_back(8'h3C);
        check_frame(q, "hold_next");
    endtask

    initial begin
        test_crc_vector();
        test_reset();
        test_single_byte();
        test_min_payload();
        test_random_frames();
        test_truncation();
        test_reset_mid_frame();
        test_hold_valid_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
